// File: rtl/sys_clk_pkg.sv
// Shared constants for the clock-gating controller: legacy state encodings,
// default timing parameters and the counter-width helper.
package sys_clk_pkg;

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_WAKE  = 2'b01;
  localparam logic [1:0] ST_ON    = 2'b11;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_WAKE_CYCLES = 2;
  localparam int unsigned DEF_IDLE_CYCLES = 8;

  // Width of a down-counter that must hold max(wake, idle).
  function automatic int unsigned cnt_width(input int unsigned wake_c,
                                            input int unsigned idle_c);
    int unsigned m;
    m = (wake_c > idle_c) ? wake_c : idle_c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: enable latched while the clock is low, then ANDed
// with the clock. Swapped for the library ICG at synthesis.
module clk_gate_cell (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic gclk_o
);

  logic en_lat_q;

  // Transparent only in the low phase, so the gate can change only while clk_i is low.
  always_latch begin
    if (!clk_i) begin
      en_lat_q <= en_i | test_en_i;
    end
  end

  assign gclk_o = en_lat_q & clk_i;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel request/ack FSM with
// wake-up delay and idle hysteresis, each driving one glitch-free gate cell.
module clk_gate_ctrl
  import sys_clk_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TEST_EN,
  input  logic [NUM_CH-1:0] CH_REQ,
  output logic [NUM_CH-1:0] CH_ACK,
  output logic [NUM_CH-1:0] CH_ACTIVE,
  output logic              ALL_IDLE,
  output logic [NUM_CH-1:0] GATED_CLK
);

  localparam int unsigned      CNT_W     = cnt_width(WAKE_CYCLES, IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [NUM_CH-1:0] off_d;
  logic              all_idle_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, act_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_OFF: begin
          if (CH_REQ[g]) begin
            state_d = ST_WAKE;
            cnt_d   = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          if (!CH_REQ[g]) begin
            state_d = ST_DRAIN;
            cnt_d   = IDLE_LOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_ON;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_ON: begin
          if (!CH_REQ[g]) begin
            state_d = ST_DRAIN;
            cnt_d   = IDLE_LOAD;
          end
        end
        ST_DRAIN: begin
          // Clock is still running here, so a new request skips the wake delay.
          if (CH_REQ[g]) begin
            state_d = ST_ON;
          end else if (cnt_q == '0) begin
            state_d = ST_OFF;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        ack_q   <= 1'b0;
        act_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ack_q   <= (state_d == ST_ON);
        act_q   <= (state_d != ST_OFF);
      end
    end

    assign off_d[g]     = (state_d == ST_OFF);
    assign CH_ACK[g]    = ack_q;
    assign CH_ACTIVE[g] = act_q;

    clk_gate_cell u_cell (
      .clk_i     (CLK),
      .en_i      (act_q),
      .test_en_i (TEST_EN),
      .gclk_o    (GATED_CLK[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      all_idle_q <= 1'b1;
    end else begin
      all_idle_q <= &off_d;
    end
  end

  assign ALL_IDLE = all_idle_q;

endmodule
